assoc_cache_lru: RTL and testbench
==================================

// Module: assoc_cache_lru
// PURPOSE
//  Parametrised fully associative write-back cache with true-LRU replacement, between the
//  processor data port and RAM. Generalises the 4-entry cache to ENTRIES lines, adds dirty
//  bits (write-back only on dirty eviction) and valid/ready + ack handshakes on split buses.
// PARAMETERS
//  D_WIDTH  8  data width (one word per line)
//  A_WIDTH  8  address width (full address stored as tag)
//  ENTRIES  4  number of lines, power of two, >=2; AGE_W = $clog2(ENTRIES)
//  STAT_W  16  statistics counter width (CACHE_STATS_EN only)
// PORTS
//  clk        in   1        clock; all logic on posedge
//  clr        in   1        synchronous, active-high reset
//  req_valid  in   1        CPU request present
//  req_ready  out  1        cache can accept; transfer = req_valid & req_ready at posedge
//  req_rw     in   1        1 = read, 0 = write
//  req_addr   in   A_WIDTH  request address
//  req_wdata  in   D_WIDTH  write data
//  rsp_valid  out  1        one-cycle pulse: request complete (reads: rsp_rdata valid)
//  rsp_rdata  out  D_WIDTH  read data, held until next rsp_valid
//  mem_ce     out  1        RAM access active; held until mem_ack sampled high
//  mem_rw     out  1        1 = RAM read (fill), 0 = RAM write (write-back)
//  mem_addr   out  A_WIDTH  RAM address, stable while mem_ce=1
//  mem_wdata  out  D_WIDTH  write-back data, stable while mem_ce=1
//  mem_rdata  in   D_WIDTH  fill data, sampled on the cycle mem_ack=1
//  mem_ack    in   1        RAM completes current access (earliest: 1st cycle of mem_ce)
// BEHAVIOUR
//  Reset: req_ready=1, rsp_valid=0, rsp_rdata=0, mem_ce=0, mem_rw=0, mem_addr=0,
//   mem_wdata=0; all valid/dirty/age=0; state IDLE. clr wins over every other input.
//  FSM: IDLE -> (hit) RESP | (miss, victim dirty) WB | (read miss, victim clean) FILL |
//   (write miss, victim clean) RESP. WB --ack--> FILL if read, RESP if write. FILL --ack--> RESP.
//   RESP -> IDLE (rsp_valid=1 during RESP). req_ready=1 only in IDLE.
//  Request is registered at accept; hit lookup uses registered addr in the following cycle.
//  Latency (accept edge to rsp_valid): hit 2 cycles; clean write miss 2; read miss
//   3 + RAM wait; dirty-victim miss adds one RAM write-back.
//  Write hit/miss: line data=wdata, valid=1, dirty=1; write miss allocates, no fill (1-word line).
//  Read fill: line data=mem_rdata, valid=1, dirty=0; rsp_rdata=mem_rdata.
//  Victim: lowest-index invalid line; else the line with age 0.
//  LRU ages: unique 0..ENTRIES-1 among valid lines. On access to line k (hit or allocate):
//   every valid line with age > age[k] (hit) or every valid line (allocate) decrements; age[k]=ENTRIES-1.
//   Ages never wrap below 0.
//  mem_ce drops the cycle after ack; back-to-back WB->FILL has one-cycle mem_ce low gap.
//  Reset mid-operation: access abandoned, mem_ce=0 next cycle, dirty data discarded.
//  req_valid ignored while req_ready=0; rsp_valid not gated by any CPU-side ready.
// CONFIGURATION
//  CACHE_STATS_EN defined: extra outputs hit_cnt, miss_cnt, wb_cnt (STAT_W each), incremented
//   per lookup result / per completed write-back, saturate at all-ones, cleared by clr.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package cache_pkg: FSM state encoding (IDLE, WB, FILL, RESP), RW_READ/RW_WRITE constants.
//  Sub-module cache_lookup: combinational tag compare, hit, hit index, victim index, per-line
//   decrement vector from addr/valid/age arrays.
// TESTING
//  1 Read 0x10 cold, RAM returns 0x5A after 2 waits -> mem_ce=1,mem_rw=1,addr 0x10; rsp 0x5A; re-read hits, latency 2, no mem_ce.
//  2 Write 0x20<-0x33 then read 0x20 -> no RAM traffic; rsp_rdata=0x33; dirty set.
//  3 Fill 4 lines 0x00..0x03, touch 0x00, access 0x04 -> victim is 0x01 (age 0), evict order matches LRU model.
//  4 Dirty victim (0x20=0x33) evicted by read 0x40 -> RAM write 0x20/0x33 then RAM read 0x40, rsp after fill.
//  5 Assert clr during FILL wait -> mem_ce=0 next cycle, req_ready=1, prior hits now miss.
//  6 CACHE_STATS_EN: scenarios 1-4 -> hit_cnt/miss_cnt/wb_cnt match scoreboard; STAT_W=2 saturates at 3.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the fully associative LRU cache: FSM encoding and RAM direction codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package cache_pkg;

    // LOOKUP is the cycle after accept, where the registered address is compared against the tags
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_FILL   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/cache_lookup.sv
// Tag compare, victim choice and LRU age-decrement vector for the associative cache.
// Latency: purely combinational.
// Backpressure: none; outputs follow the inputs within the cycle.
module cache_lookup #(
    parameter int ENTRIES = 4,
    parameter int A_WIDTH = 8,
    parameter int AGE_W   = 2
) (
    input  logic [A_WIDTH-1:0]              addr,
    input  logic [ENTRIES-1:0]              valid,
    input  logic [ENTRIES-1:0][A_WIDTH-1:0] tags,
    input  logic [ENTRIES-1:0][AGE_W-1:0]   ages,
    output logic                            hit,
    output logic [AGE_W-1:0]                hit_idx,
    output logic [AGE_W-1:0]                victim_idx,
    output logic [ENTRIES-1:0]              dec_vec
);

    logic             found_inv;
    logic [AGE_W-1:0] hit_age;

    // Find the (at most one) line whose tag matches the address
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && (tags[i] == addr) && !hit) begin
                hit     = 1'b1;
                hit_idx = AGE_W'(i);
            end
        end
    end

    // Victim: lowest-index invalid line wins, otherwise the line whose age has reached 0
    always_comb begin
        victim_idx = '0;
        found_inv  = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && (ages[i] == '0)) begin
                victim_idx = AGE_W'(i);
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid[i] && !found_inv) begin
                found_inv  = 1'b1;
                victim_idx = AGE_W'(i);
            end
        end
    end

    // On a hit only lines younger than the hit line age; on allocate every valid line ages, floored at 0
    always_comb begin
        hit_age = ages[hit_idx];
        dec_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            dec_vec[i] = valid[i] && (hit ? (ages[i] > hit_age) : (ages[i] != '0));
        end
    end

endmodule

// File: rtl/assoc_cache_lru.sv
// Fully associative write-back cache, true-LRU replacement; CACHE_STATS_EN adds hit/miss/wb counters.
// Latency: hit / clean write miss 2 cycles, read miss 3 + RAM wait, dirty victim adds one RAM write-back.
// Backpressure: req_ready only in IDLE; RAM side holds mem_ce until mem_ack; rsp_valid is never stalled.
module assoc_cache_lru
    import cache_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8,
    parameter int ENTRIES = 4
`ifdef CACHE_STATS_EN
    ,
    parameter int STAT_W  = 16
`endif
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rw,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic               mem_ce,
    output logic               mem_rw,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata,
    input  logic               mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]  hit_cnt,
    output logic [STAT_W-1:0]  miss_cnt,
    output logic [STAT_W-1:0]  wb_cnt
`endif
);

    localparam int              AGE_W   = $clog2(ENTRIES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ENTRIES - 1);

    state_t                            state_q, state_d;
    logic                              req_rw_q, req_rw_d;
    logic [A_WIDTH-1:0]                req_addr_q, req_addr_d;
    logic [D_WIDTH-1:0]                req_wdata_q, req_wdata_d;
    logic [AGE_W-1:0]                  victim_q, victim_d;
    logic [ENTRIES-1:0]                valid_q, valid_d;
    logic [ENTRIES-1:0]                dirty_q, dirty_d;
    logic [ENTRIES-1:0][A_WIDTH-1:0]   tag_q, tag_d;
    logic [ENTRIES-1:0][D_WIDTH-1:0]   data_q, data_d;
    logic [ENTRIES-1:0][AGE_W-1:0]     age_q, age_d;
    logic                              rsp_valid_q, rsp_valid_d;
    logic [D_WIDTH-1:0]                rsp_rdata_q, rsp_rdata_d;
    logic                              mem_ce_q, mem_ce_d;
    logic                              mem_rw_q, mem_rw_d;
    logic [A_WIDTH-1:0]                mem_addr_q, mem_addr_d;
    logic [D_WIDTH-1:0]                mem_wdata_q, mem_wdata_d;

    logic                              hit;
    logic [AGE_W-1:0]                  hit_idx;
    logic [AGE_W-1:0]                  victim_idx;
    logic [ENTRIES-1:0]                dec_vec;

    // Per-cycle line update request from the FSM
    logic                              touch;
    logic                              line_wr;
    logic [AGE_W-1:0]                  line_idx;
    logic [D_WIDTH-1:0]                line_data;
    logic                              line_dirty;

    cache_lookup #(
        .ENTRIES (ENTRIES),
        .A_WIDTH (A_WIDTH),
        .AGE_W   (AGE_W)
    ) u_lookup (
        .addr       (req_addr_q),
        .valid      (valid_q),
        .tags       (tag_q),
        .ages       (age_q),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .victim_idx (victim_idx),
        .dec_vec    (dec_vec)
    );

    // FSM next state, RAM port, response and line/age updates
    always_comb begin
        state_d     = state_q;
        req_rw_d    = req_rw_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        victim_d    = victim_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        age_d       = age_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_ce_d    = mem_ce_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        touch       = 1'b0;
        line_wr     = 1'b0;
        line_idx    = victim_q;
        line_data   = req_wdata_q;
        line_dirty  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_rw_d    = req_rw;
                    req_addr_d  = req_addr;
                    req_wdata_d = req_wdata;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                victim_d = victim_idx;
                if (hit) begin
                    touch    = 1'b1;
                    line_idx = hit_idx;
                    if (req_rw_q == RW_READ) begin
                        rsp_rdata_d = data_q[hit_idx];
                    end else begin
                        line_wr = 1'b1;
                    end
                    state_d = ST_RESP;
                end else if (valid_q[victim_idx] && dirty_q[victim_idx]) begin
                    mem_ce_d    = 1'b1;
                    mem_rw_d    = RW_WRITE;
                    mem_addr_d  = tag_q[victim_idx];
                    mem_wdata_d = data_q[victim_idx];
                    state_d     = ST_WB;
                end else if (req_rw_q == RW_READ) begin
                    mem_ce_d   = 1'b1;
                    mem_rw_d   = RW_READ;
                    mem_addr_d = req_addr_q;
                    state_d    = ST_FILL;
                end else begin
                    // Single-word line: a write miss allocates without fetching
                    touch    = 1'b1;
                    line_wr  = 1'b1;
                    line_idx = victim_idx;
                    state_d  = ST_RESP;
                end
            end
            ST_WB: begin
                if (mem_ack) begin
                    mem_ce_d = 1'b0;
                    if (req_rw_q == RW_READ) begin
                        state_d = ST_FILL;
                    end else begin
                        touch   = 1'b1;
                        line_wr = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_FILL: begin
                if (!mem_ce_q) begin
                    // Arrived from WB: mem_ce was low for one cycle, start the fill now
                    mem_ce_d   = 1'b1;
                    mem_rw_d   = RW_READ;
                    mem_addr_d = req_addr_q;
                end else if (mem_ack) begin
                    mem_ce_d    = 1'b0;
                    touch       = 1'b1;
                    line_wr     = 1'b1;
                    line_data   = mem_rdata;
                    line_dirty  = 1'b0;
                    rsp_rdata_d = mem_rdata;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (touch) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (dec_vec[i]) begin
                    age_d[i] = age_q[i] - AGE_W'(1);
                end
            end
            age_d[line_idx] = AGE_MAX;
        end

        if (line_wr) begin
            valid_d[line_idx] = 1'b1;
            dirty_d[line_idx] = line_dirty;
            tag_d[line_idx]   = req_addr_q;
            data_d[line_idx]  = line_data;
        end

        rsp_valid_d = (state_d == ST_RESP);
    end

    // State registers; clr abandons any access and discards all lines
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            req_rw_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            age_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_ce_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_rw_q    <= req_rw_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            victim_q    <= victim_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            age_q       <= age_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_ce_q    <= mem_ce_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_ce    = mem_ce_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [STAT_W-1:0] wb_cnt_q, wb_cnt_d;

    // Saturating event counters: one lookup result per request, one count per acked write-back
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if ((state_q == ST_LOOKUP) && hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + STAT_W'(1);
        end
        if ((state_q == ST_LOOKUP) && !hit && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + STAT_W'(1);
        end
        if ((state_q == ST_WB) && mem_ack && (wb_cnt_q != '1)) begin
            wb_cnt_d = wb_cnt_q + STAT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_cache_lru.sv
// Bench for assoc_cache_lru: LRU-list reference model feeds response and RAM-transaction scoreboards.
// Latency: checks per-request latency against the model.
// Backpressure: RAM responder inserts a programmable number of wait cycles before mem_ack.
module tb_assoc_cache_lru;

    localparam int ENTRIES = 4;

    typedef struct {
        logic [7:0] rd;
        int         lat;
        int         txns;
    } rsp_exp_t;

    typedef struct {
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } mem_exp_t;

    logic       clk;
    logic       clr;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mem_ce;
    logic       mem_rw;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int mem_txn = 0;
    int ram_wait = 0;
    int wcnt = 0;
    bit in_acc = 0;
    logic [7:0] cur_addr;

    // Reference model state
    logic [7:0] lru_q[$];
    logic [7:0] m_data[logic [7:0]];
    bit         m_dirty[logic [7:0]];
    logic [7:0] exp_ram[logic [7:0]];
    logic [7:0] tb_ram[logic [7:0]];
    logic [7:0] last_rd = 8'h00;
    int         m_hits = 0, m_misses = 0, m_wbs = 0;
    rsp_exp_t   exp_rsp_q[$];
    mem_exp_t   exp_mem_q[$];

    assoc_cache_lru #(
        .D_WIDTH (8),
        .A_WIDTH (8),
        .ENTRIES (ENTRIES)
`ifdef CACHE_STATS_EN
        ,
        .STAT_W  (16)
`endif
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_ce    (mem_ce),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .wb_cnt    (wb_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] exp_ram_val(input logic [7:0] a);
        return exp_ram.exists(a) ? exp_ram[a] : (a ^ 8'hA5);
    endfunction

    function automatic logic [7:0] tb_ram_val(input logic [7:0] a);
        return tb_ram.exists(a) ? tb_ram[a] : (a ^ 8'hA5);
    endfunction

    // RAM responder: checks each new access against the expected-transaction queue
    always @(negedge clk) begin
        if (!mem_ce) begin
            mem_ack = 1'b0;
            in_acc  = 1'b0;
        end else if (mem_ack) begin
            tests_run++;
            tests_failed++;
            $display("FAIL mem_ce_drop: mem_ce=1 want 0 in cycle after ack");
            mem_ack = 1'b0;
            in_acc  = 1'b0;
        end else begin
            if (!in_acc) begin
                mem_exp_t m;
                in_acc   = 1'b1;
                wcnt     = 0;
                mem_txn++;
                cur_addr = mem_addr;
                tests_run++;
                if (exp_mem_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL mem_txn: unexpected access rw=%0d addr=%h, want none", mem_rw, mem_addr);
                end else begin
                    m = exp_mem_q.pop_front();
                    if (mem_rw !== m.rw || mem_addr !== m.addr || (!m.rw && mem_wdata !== m.wdata)) begin
                        tests_failed++;
                        $display("FAIL mem_txn: got rw=%0d addr=%h wdata=%h, want rw=%0d addr=%h wdata=%h",
                                 mem_rw, mem_addr, mem_wdata, m.rw, m.addr, m.wdata);
                    end
                end
            end
            if (wcnt >= ram_wait) begin
                tests_run++;
                if (mem_addr !== cur_addr) begin
                    tests_failed++;
                    $display("FAIL mem_addr_stable: got %h want %h", mem_addr, cur_addr);
                end
                mem_ack = 1'b1;
                if (mem_rw) mem_rdata = tb_ram_val(mem_addr);
                else        tb_ram[mem_addr] = mem_wdata;
            end else begin
                wcnt++;
            end
        end
    end

    task automatic model_reset();
        lru_q.delete();
        m_data.delete();
        m_dirty.delete();
        exp_rsp_q.delete();
        exp_mem_q.delete();
        last_rd  = 8'h00;
        m_hits   = 0;
        m_misses = 0;
        m_wbs    = 0;
    endtask

    // LRU list model: front of lru_q is least recently used
    task automatic model_access(input bit rw, input logic [7:0] a, input logic [7:0] d);
        int pos;
        rsp_exp_t e;
        mem_exp_t m;
        logic [7:0] v;
        pos    = -1;
        e.lat  = 2;
        e.txns = 0;
        e.rd   = last_rd;
        foreach (lru_q[i]) if (lru_q[i] == a) pos = i;
        if (pos >= 0) begin
            m_hits++;
            lru_q.delete(pos);
            if (rw) e.rd = m_data[a];
            else begin m_data[a] = d; m_dirty[a] = 1'b1; end
        end else begin
            m_misses++;
            if (lru_q.size() == ENTRIES) begin
                v = lru_q.pop_front();
                if (m_dirty[v]) begin
                    m.rw = 1'b0; m.addr = v; m.wdata = m_data[v];
                    exp_mem_q.push_back(m);
                    exp_ram[v] = m_data[v];
                    e.txns++;
                    e.lat += 1 + ram_wait + (rw ? 1 : 0);
                    m_wbs++;
                end
                m_data.delete(v);
                m_dirty.delete(v);
            end
            if (rw) begin
                m.rw = 1'b1; m.addr = a; m.wdata = 8'h00;
                exp_mem_q.push_back(m);
                e.txns++;
                e.lat += 1 + ram_wait;
                m_data[a]  = exp_ram_val(a);
                m_dirty[a] = 1'b0;
                e.rd = m_data[a];
            end else begin
                m_data[a]  = d;
                m_dirty[a] = 1'b1;
            end
        end
        lru_q.push_back(a);
        if (rw) last_rd = e.rd;
        exp_rsp_q.push_back(e);
    endtask

    // Drives one request, waits (bounded) for its response, reports what the DUT did
    task automatic do_req(input bit rw, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output int txns, output bit to);
        int n;
        int acc;
        int t0;
        t0 = mem_txn;
        model_access(rw, a, d);
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        to  = !req_ready;
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        if (!rsp_valid) to = 1'b1;
        lat  = cyc + 1 - acc;
        rd   = rsp_rdata;
        txns = mem_txn - t0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        tests_run += 7;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
        if (mem_ce !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_ce: got %b want 0", mem_ce); end
        if (mem_rw !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_rw: got %b want 0", mem_rw); end
        if (mem_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        if (mem_wdata !== 8'h00) begin tests_failed++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
`ifdef CACHE_STATS_EN
        tests_run++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || wb_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", hit_cnt, miss_cnt, wb_cnt);
        end
`endif
        clr = 1'b0;
        model_reset();
    endtask

    // Cold read with 2 RAM waits, then a re-read that must hit
    task automatic test_read_fill();
        logic [7:0] rd; int lat, txns; bit to; rsp_exp_t e;
        ram_wait = 2;
        for (int k = 0; k < 2; k++) begin
            do_req(1'b1, 8'h10, 8'h00, rd, lat, txns, to);
            e = exp_rsp_q.pop_front();
            tests_run += 5;
            if (to) begin tests_failed++; $display("FAIL fill_timeout op%0d: timed out, want response", k); end
            if (rd !== e.rd) begin tests_failed++; $display("FAIL fill_rdata op%0d: got %h want %h", k, rd, e.rd); end
            if (rd !== 8'h5A) begin tests_failed++; $display("FAIL fill_rdata_5a op%0d: got %h want 5a", k, rd); end
            if (lat !== e.lat) begin tests_failed++; $display("FAIL fill_latency op%0d: got %0d want %0d", k, lat, e.lat); end
            if (txns !== e.txns) begin tests_failed++; $display("FAIL fill_ramtxn op%0d: got %0d want %0d", k, txns, e.txns); end
        end
    endtask

    // Write allocate without RAM traffic, then read back
    task automatic test_write_hit();
        logic [7:0] rd; int lat, txns; bit to; rsp_exp_t e;
        bit rws[2] = '{1'b0, 1'b1};
        ram_wait = 1;
        for (int k = 0; k < 2; k++) begin
            do_req(rws[k], 8'h20, 8'h33, rd, lat, txns, to);
            e = exp_rsp_q.pop_front();
            tests_run += 4;
            if (to) begin tests_failed++; $display("FAIL wr_timeout op%0d: timed out, want response", k); end
            if (rd !== e.rd) begin tests_failed++; $display("FAIL wr_rdata op%0d: got %h want %h", k, rd, e.rd); end
            if (lat !== e.lat) begin tests_failed++; $display("FAIL wr_latency op%0d: got %0d want %0d", k, lat, e.lat); end
            if (txns !== e.txns) begin tests_failed++; $display("FAIL wr_ramtxn op%0d: got %0d want %0d", k, txns, e.txns); end
        end
    endtask

    // Fill all lines, refresh 0x00, then 0x04 must evict 0x01
    task automatic test_lru();
        logic [7:0] rd; int lat, txns; bit to; rsp_exp_t e;
        logic [7:0] addrs[8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h00, 8'h01};
        do_clr();
        ram_wait = 0;
        for (int k = 0; k < 8; k++) begin
            do_req(1'b1, addrs[k], 8'h00, rd, lat, txns, to);
            e = exp_rsp_q.pop_front();
            tests_run += 4;
            if (to) begin tests_failed++; $display("FAIL lru_timeout op%0d: timed out, want response", k); end
            if (rd !== e.rd) begin tests_failed++; $display("FAIL lru_rdata op%0d: got %h want %h", k, rd, e.rd); end
            if (lat !== e.lat) begin tests_failed++; $display("FAIL lru_latency op%0d: got %0d want %0d", k, lat, e.lat); end
            if (txns !== e.txns) begin tests_failed++; $display("FAIL lru_ramtxn op%0d: got %0d want %0d", k, txns, e.txns); end
        end
    endtask

    // Dirty 0x20 becomes LRU and is written back before 0x40 fills; reading 0x20 again returns 0x33 from RAM
    task automatic test_dirty_evict();
        logic [7:0] rd; int lat, txns; bit to; rsp_exp_t e;
        bit         rws[6]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] addrs[6] = '{8'h20, 8'h01, 8'h02, 8'h03, 8'h40, 8'h20};
        do_clr();
        ram_wait = 1;
        for (int k = 0; k < 6; k++) begin
            do_req(rws[k], addrs[k], 8'h33, rd, lat, txns, to);
            e = exp_rsp_q.pop_front();
            tests_run += 4;
            if (to) begin tests_failed++; $display("FAIL dirty_timeout op%0d: timed out, want response", k); end
            if (rd !== e.rd) begin tests_failed++; $display("FAIL dirty_rdata op%0d: got %h want %h", k, rd, e.rd); end
            if (lat !== e.lat) begin tests_failed++; $display("FAIL dirty_latency op%0d: got %0d want %0d", k, lat, e.lat); end
            if (txns !== e.txns) begin tests_failed++; $display("FAIL dirty_ramtxn op%0d: got %0d want %0d", k, txns, e.txns); end
        end
        tests_run++;
        if (rd !== 8'h33) begin tests_failed++; $display("FAIL dirty_wb_data: got %h want 33", rd); end
`ifdef CACHE_STATS_EN
        tests_run++;
        if (hit_cnt !== 16'(m_hits) || miss_cnt !== 16'(m_misses) || wb_cnt !== 16'(m_wbs)) begin
            tests_failed++;
            $display("FAIL dirty_stats: got %0d/%0d/%0d want %0d/%0d/%0d",
                     hit_cnt, miss_cnt, wb_cnt, m_hits, m_misses, m_wbs);
        end
`endif
    endtask

    // clr during a long fill wait abandons the access and empties the cache
    task automatic test_clr_mid();
        logic [7:0] rd; int lat, txns; bit to; rsp_exp_t e; int n;
        do_clr();
        ram_wait = 0;
        do_req(1'b1, 8'h55, 8'h00, rd, lat, txns, to);
        e = exp_rsp_q.pop_front();
        ram_wait = 20;
        model_access(1'b1, 8'h66, 8'h00);
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h66;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (mem_ce !== 1'b1) begin tests_failed++; $display("FAIL clr_pre_mem_ce: got %b want 1", mem_ce); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tests_run += 3;
        if (mem_ce !== 1'b0) begin tests_failed++; $display("FAIL clr_mem_ce: got %b want 0", mem_ce); end
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL clr_req_ready: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_rsp_valid: got %b want 0", rsp_valid); end
        model_reset();
        ram_wait = 0;
        do_req(1'b1, 8'h55, 8'h00, rd, lat, txns, to);
        e = exp_rsp_q.pop_front();
        tests_run += 3;
        if (to) begin tests_failed++; $display("FAIL clr_timeout: timed out, want response"); end
        if (txns !== 1) begin tests_failed++; $display("FAIL clr_now_miss: ram txns %0d want 1", txns); end
        if (rd !== e.rd) begin tests_failed++; $display("FAIL clr_rdata: got %h want %h", rd, e.rd); end
    endtask

    // Pseudo-random mix of reads/writes over 8 addresses with varying RAM wait
    task automatic test_back_to_back();
        logic [7:0] rd; int lat, txns; bit to; rsp_exp_t e;
        bit rw; logic [7:0] a, d;
        do_clr();
        for (int k = 0; k < 40; k++) begin
            ram_wait = $urandom_range(0, 2);
            rw = 1'($urandom_range(0, 1));
            a  = 8'h80 + 8'($urandom_range(0, 7));
            d  = 8'($urandom_range(0, 255));
            do_req(rw, a, d, rd, lat, txns, to);
            e = exp_rsp_q.pop_front();
            tests_run += 4;
            if (to) begin tests_failed++; $display("FAIL b2b_timeout op%0d: timed out, want response", k); end
            if (rd !== e.rd) begin tests_failed++; $display("FAIL b2b_rdata op%0d: got %h want %h", k, rd, e.rd); end
            if (lat !== e.lat) begin tests_failed++; $display("FAIL b2b_latency op%0d: got %0d want %0d", k, lat, e.lat); end
            if (txns !== e.txns) begin tests_failed++; $display("FAIL b2b_ramtxn op%0d: got %0d want %0d", k, txns, e.txns); end
        end
        tests_run++;
        if (exp_mem_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_mem_left: %0d expected RAM accesses never seen, want 0", exp_mem_q.size());
        end
`ifdef CACHE_STATS_EN
        tests_run++;
        if (hit_cnt !== 16'(m_hits) || miss_cnt !== 16'(m_misses) || wb_cnt !== 16'(m_wbs)) begin
            tests_failed++;
            $display("FAIL b2b_stats: got %0d/%0d/%0d want %0d/%0d/%0d",
                     hit_cnt, miss_cnt, wb_cnt, m_hits, m_misses, m_wbs);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr       = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        tb_ram[8'h10]  = 8'h5A;
        exp_ram[8'h10] = 8'h5A;
        test_reset();
        test_read_fill();
        test_write_hit();
        test_lru();
        test_dirty_evict();
        test_clr_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
